// File: rtl/msg_asm.sv
// Message assembler: packs WORDS_PER_PACKET serial words (first word = MSW) into one
// packet behind a valid/ready holding register. Define MSG_ASM_TIMEOUT_EN for the idle timeout.
module msg_asm #(
    parameter int WORD_SIZE        = 8,
    parameter int WORDS_PER_PACKET = 4,
    parameter int TIMEOUT_CYCLES   = 1000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [WORD_SIZE-1:0]                  data_in,
    input  logic                                  data_in_valid,
    output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out,
    output logic                                  data_out_valid,
    input  logic                                  data_out_ready,
    output logic                                  busy,
    output logic                                  overrun,
    output logic                                  timeout
);

    localparam int PW = WORD_SIZE * WORDS_PER_PACKET;
    // Only the leading words are stored; the final word comes straight from data_in.
    localparam int SW = WORD_SIZE * (WORDS_PER_PACKET - 1);
    localparam int CW = $clog2(WORDS_PER_PACKET);

    typedef enum logic {C_IDLE, C_COLLECT} colState_t;
    typedef enum logic {O_EMPTY, O_FULL} outState_t;

    colState_t         colState_q, colState_d;
    outState_t         outState_q, outState_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     data_q, data_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              complete;
    logic              expire;
    logic [PW-1:0]     packet;

`ifdef MSG_ASM_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IW-1:0] idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        expire = 1'b0;
        if (data_in_valid || (count_q == '0)) begin
            idle_d = '0;
        end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
            idle_d = '0;
            expire = 1'b1;
        end else begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    // Without the idle counter a partial packet simply waits forever.
    assign expire = (TIMEOUT_CYCLES < 0);
`endif

    assign packet = {shift_q, data_in};

    always_comb begin
        colState_d = colState_q;
        outState_d = outState_q;
        shift_d    = shift_q;
        count_d    = count_q;
        data_d     = data_q;
        overrun_d  = 1'b0;
        timeout_d  = expire;
        complete   = 1'b0;

        case (colState_q)
            C_IDLE: begin
                if (data_in_valid) begin
                    shift_d    = SW'(data_in);
                    count_d    = CW'(1);
                    colState_d = C_COLLECT;
                end
            end
            C_COLLECT: begin
                if (data_in_valid) begin
                    if (count_q == CW'(WORDS_PER_PACKET - 1)) begin
                        complete   = 1'b1;
                        count_d    = '0;
                        colState_d = C_IDLE;
                    end else begin
                        shift_d = (shift_q << WORD_SIZE) | SW'(data_in);
                        count_d = count_q + CW'(1);
                    end
                end else if (expire) begin
                    count_d    = '0;
                    colState_d = C_IDLE;
                end
            end
        endcase

        // A full holding register can only take a new packet if it drains this cycle.
        case (outState_q)
            O_EMPTY: begin
                if (complete) begin
                    data_d     = packet;
                    outState_d = O_FULL;
                end
            end
            O_FULL: begin
                if (complete) begin
                    if (data_out_ready) begin
                        data_d = packet;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (data_out_ready) begin
                    outState_d = O_EMPTY;
                end
            end
        endcase

        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colState_q <= C_IDLE;
            outState_q <= O_EMPTY;
            shift_q    <= '0;
            count_q    <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            colState_q <= colState_d;
            outState_q <= outState_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = (outState_q == O_FULL);
    assign busy           = busy_q;
    assign overrun        = overrun_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_msg_asm.sv
// Bench for msg_asm: directed scenarios plus random traffic against a packet-level
// model built from a word queue. Honours MSG_ASM_TIMEOUT_EN like the design.
module tb_msg_asm;

    localparam int WS  = 8;
    localparam int WPP = 4;
    localparam int TO  = 20;
`ifdef MSG_ASM_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  dataIn;
    logic        dataInValid;
    logic [31:0] dataOut;
    logic        dataOutValid;
    logic        dataOutReady;
    logic        busy;
    logic        overrun;
    logic        timeout;
    logic [35:0] obsVec;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mWords[$];
    logic [31:0] mData;
    bit          mFull;
    bit          mOverrun;
    bit          mTimeout;
    int          mIdle;

    always #5 clk = ~clk;

    msg_asm #(
        .WORD_SIZE       (WS),
        .WORDS_PER_PACKET(WPP),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (dataIn),
        .data_in_valid (dataInValid),
        .data_out      (dataOut),
        .data_out_valid(dataOutValid),
        .data_out_ready(dataOutReady),
        .busy          (busy),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    assign obsVec = {dataOut, dataOutValid, busy, overrun, timeout};

    function automatic void modelReset();
        mWords.delete();
        mData    = '0;
        mFull    = 1'b0;
        mOverrun = 1'b0;
        mTimeout = 1'b0;
        mIdle    = 0;
    endfunction

    // One clock edge of the packet-level view: words accumulate in a queue, a packet
    // is their concatenation, and the output holds at most one packet.
    function automatic void modelEdge(bit v, logic [7:0] d, bit r);
        bit          done = 1'b0;
        logic [31:0] pkt  = '0;
        mOverrun = 1'b0;
        mTimeout = 1'b0;
        if (v) begin
            mWords.push_back(d);
            mIdle = 0;
            if (mWords.size() == WPP) begin
                for (int i = 0; i < WPP; i++) pkt = (pkt << WS) | 32'(mWords[i]);
                mWords.delete();
                done = 1'b1;
            end
        end else if (TIMEOUT_ON && mWords.size() != 0) begin
            mIdle++;
            if (mIdle == TO) begin
                mWords.delete();
                mIdle    = 0;
                mTimeout = 1'b1;
            end
        end
        if (done) begin
            if (!mFull || r) begin
                mData = pkt;
                mFull = 1'b1;
            end else begin
                mOverrun = 1'b1;
            end
        end else if (mFull && r) begin
            mFull = 1'b0;
        end
    endfunction

    function automatic logic [35:0] expVec();
        return {mData, mFull, (mWords.size() != 0), mOverrun, mTimeout};
    endfunction

    task automatic drive(input bit v, input logic [7:0] d, input bit r);
        dataInValid  = v;
        dataIn       = v ? d : 8'($urandom);
        dataOutReady = r;
        @(posedge clk);
        modelEdge(v, d, r);
        #1;
    endtask

    task automatic doReset();
        reset       = 1'b1;
        dataInValid = 1'b0;
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        dataIn       = '0;
        dataInValid  = 1'b0;
        dataOutReady = 1'b1;
        modelReset();
        #2;
        checks++;
        if (obsVec !== 36'h0) begin
            failures++;
            $display("[TB] FAIL reset_state got %h want %h", obsVec, 36'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (obsVec !== expVec()) begin
            failures++;
            $display("[TB] FAIL reset_release got %h want %h", obsVec, expVec());
        end
    endtask

    task automatic test_facebeef();
        logic [7:0]  words[4] = '{8'hFA, 8'hCE, 8'hBE, 8'hEF};
        int          validCycles = 0;
        logic [31:0] seen = '0;
        doReset();
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 10; c++) begin
                drive(c == 0, words[w], 1'b1);
                checks++;
                if (obsVec !== expVec()) begin
                    failures++;
                    $display("[TB] FAIL facebeef w%0d c%0d got %h want %h", w, c, obsVec, expVec());
                end
                if (dataOutValid) begin
                    validCycles++;
                    seen = dataOut;
                end
            end
        end
        checks++;
        if (validCycles != 1 || seen !== 32'hFACEBEEF) begin
            failures++;
            $display("[TB] FAIL facebeef_packet got %h x%0d want FACEBEEF x1", seen, validCycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen[$];
        int          ovr = 0;
        doReset();
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, (i < 4) ? 8'h00 : 8'hFF, 1'b1);
            checks++;
            if (obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL back_to_back c%0d got %h want %h", i, obsVec, expVec());
            end
            if (dataOutValid) seen.push_back(dataOut);
            if (overrun) ovr++;
        end
        checks++;
        if (seen.size() != 2 || ovr != 0 || seen[0] !== 32'h0 || seen[1] !== 32'hFFFFFFFF) begin
            failures++;
            $display("[TB] FAIL back_to_back_packets got n=%0d ovr=%0d want 00000000,FFFFFFFF ovr=0",
                     seen.size(), ovr);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] words[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int         ovr = 0;
        doReset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, words[i], 1'b0);
            checks++;
            if (obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL overrun c%0d got %h want %h", i, obsVec, expVec());
            end
            if (overrun) ovr++;
        end
        checks++;
        if (ovr != 1 || !overrun || dataOut !== 32'h11223344 || !dataOutValid) begin
            failures++;
            $display("[TB] FAIL overrun_hold got %h ovr=%0d want 11223344 ovr=1", dataOut, ovr);
        end
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (dataOutValid !== 1'b0 || dataOut !== 32'h11223344 || overrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun_drain got valid=%b %h want valid=0 11223344", dataOutValid, dataOut);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] words[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        int         ovr = 0;
        doReset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, words[i], i == 7);
            checks++;
            if (obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL same_cycle c%0d got %h want %h", i, obsVec, expVec());
            end
            if (overrun) ovr++;
        end
        checks++;
        if (dataOut !== 32'hAABBCCDD || !dataOutValid || ovr != 0) begin
            failures++;
            $display("[TB] FAIL same_cycle_swap got %h valid=%b ovr=%0d want AABBCCDD valid=1 ovr=0",
                     dataOut, dataOutValid, ovr);
        end
    endtask

    task automatic test_timeout();
        logic [7:0]  words[6] = '{8'h12, 8'h34, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        int          pulses = 0;
        logic [31:0] seen = '0;
        int          expPulses = TIMEOUT_ON ? 1 : 0;
        logic [31:0] expPkt = TIMEOUT_ON ? 32'hA1B2C3D4 : 32'h1234A1B2;
        doReset();
        for (int i = 0; i < 26; i++) begin
            if (i < 2) drive(1'b1, words[i], 1'b1);
            else if (i < 22) drive(1'b0, 8'h00, 1'b1);
            else drive(1'b1, words[i - 20], 1'b1);
            checks++;
            if (obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL timeout c%0d got %h want %h", i, obsVec, expVec());
            end
            if (timeout) pulses++;
            if (dataOutValid && seen === '0) seen = dataOut;
        end
        checks++;
        if (pulses != expPulses || seen !== expPkt) begin
            failures++;
            $display("[TB] FAIL timeout_packet got %h pulses=%0d want %h pulses=%0d",
                     seen, pulses, expPkt, expPulses);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] words[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        doReset();
        drive(1'b1, 8'h55, 1'b1);
        drive(1'b1, 8'h66, 1'b1);
        reset = 1'b1;
        modelReset();
        #1;
        checks++;
        if (obsVec !== 36'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid_packet got %h want %h", obsVec, 36'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, words[i % 4], 1'b0);
            checks++;
            if (obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL after_reset c%0d got %h want %h", i, obsVec, expVec());
            end
        end
        checks++;
        if (dataOut !== 32'hDEADBEEF || !dataOutValid) begin
            failures++;
            $display("[TB] FAIL after_reset_packet got %h want DEADBEEF", dataOut);
        end
    endtask

    task automatic test_random();
        int probs[3] = '{90, 30, 3};
        int prob;
        doReset();
        for (int s = 0; s < 40; s++) begin
            prob = probs[$urandom_range(0, 2)];
            for (int c = 0; c < 50; c++) begin
                drive($urandom_range(0, 99) < prob, 8'($urandom), $urandom_range(0, 9) < 7);
                checks++;
                if (obsVec !== expVec()) begin
                    failures++;
                    $display("[TB] FAIL random s%0d c%0d got %h want %h", s, c, obsVec, expVec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_facebeef();
        test_back_to_back();
        test_overrun();
        test_same_cycle();
        test_timeout();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msg_asm.md
Name: msg_asm

Overview:
- Message assembler: receive side of the UART link, mirror of the message disassembler.
- Collects WORDS_PER_PACKET serial words of WORD_SIZE bits from the UART receiver and presents them as one wide packet to the controller.
- The first word received is the most significant word, matching the disassembler's transmit order.
- Output uses a valid/ready handshake backed by a one-packet holding register, so reception continues while the controller is busy.

Parameters:
- WORD_SIZE, 8: bits per serial word.
- WORDS_PER_PACKET, 4: words per packet; must be at least 2.
- TIMEOUT_CYCLES, 1000: inter-word idle limit in clk cycles. Used only when MSG_ASM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  WORD_SIZE  received word from the UART receiver.
- data_in_valid  in  1  single-cycle strobe; data_in is valid this cycle.
- data_out  out  WORD_SIZE*WORDS_PER_PACKET  assembled packet; word 0 occupies the MSBs.
- data_out_valid  out  1  packet available; held until accepted.
- data_out_ready  in  1  controller accepts data_out when high together with data_out_valid.
- busy  out  1  partial packet in progress (word count nonzero).
- overrun  out  1  one-cycle pulse: a completed packet was dropped.
- timeout  out  1  one-cycle pulse: a partial packet was discarded on timeout.

Behaviour:
- Reset (async assert, sync release) clears:
  - data_out=0, data_out_valid=0, busy=0, overrun=0, timeout=0.
  - Shift register and word counter = 0.
  - Collector FSM = IDLE; output side = EMPTY.
- Collector FSM:
  - IDLE: data_in_valid -> shift in the word, count=1, go to COLLECT.
  - COLLECT: each data_in_valid shifts the assembly register left by WORD_SIZE and loads data_in into the LSBs; count increments.
  - When a strobe brings count to WORDS_PER_PACKET: count returns to 0 and the FSM goes to IDLE on that same edge. The completed value (including the final word) is offered to the output side.
  - busy = (count != 0), registered.
- Output side (EMPTY/FULL):
  - EMPTY + completion: load data_out, go to FULL. data_out_valid rises on the edge that accepted the last word, i.e. it is high in the cycle after the last strobe. Latency is 1 cycle.
  - FULL + data_out_ready: go to EMPTY; data_out_valid low on the next cycle. data_out holds its last value.
  - FULL + completion + data_out_ready in the same cycle: new packet loaded, stays FULL, valid stays high, no overrun.
  - FULL + completion without data_out_ready: the new packet is dropped, the old one is retained, and overrun pulses for 1 cycle. The collector still restarts at count 0.
- data_out is stable while data_out_valid is high.
- data_in_valid is ignored when low; data_in may change freely. No backpressure toward the UART; every strobe is consumed.
- Reset asserted mid-packet: the partial packet is discarded with no pulse on any output.

Optional Feature:
- Macro MSG_ASM_TIMEOUT_EN.
- Defined:
  - An idle counter counts clk cycles while busy=1 and data_in_valid=0; any strobe clears it.
  - When it reaches TIMEOUT_CYCLES: word count and idle counter clear, the FSM goes to IDLE, and timeout pulses 1 cycle. Output side is unaffected.
  - A strobe in the same cycle as expiry takes priority: it is accepted normally and no timeout occurs.
- Not defined: timeout is tied to 0, there is no idle counter, and a partial packet is held indefinitely.

Test Plan (WORD_SIZE=8, WORDS_PER_PACKET=4, TIMEOUT_CYCLES=20, data_out_ready=1 unless stated):
- Strobes FA, CE, BE, EF, 10 cycles apart -> data_out=32'hFACEBEEF, data_out_valid high exactly 1 cycle, starting the cycle after the EF strobe. busy high from the FA edge until the EF edge.
- Strobes 00,00,00,00 then FF,FF,FF,FF -> two packets 32'h00000000 then 32'hFFFFFFFF, no overrun.
- data_out_ready=0; send 11223344 then 55667788 ->
  - data_out stays 32'h11223344 with valid held high.
  - overrun pulses once on the 88 edge.
  - Raising ready drains 11223344; valid then falls.
- data_out_ready=0; send 11223344; raise ready in the same cycle as the final strobe of AABBCCDD -> data_out=32'hAABBCCDD, valid stays high, no overrun.
- With MSG_ASM_TIMEOUT_EN: send 12, 34, then idle 20 cycles -> timeout pulses, busy falls. Then A1 B2 C3 D4 -> 32'hA1B2C3D4. Without the macro: the same stimulus gives no timeout pulse and output 32'h1234A1B2.
- Assert reset after 2 words of a packet -> all outputs 0 immediately. Then DEADBEEF -> 32'hDEADBEEF.
